// File: rtl/axi4_mem_slave_responder.sv
// AXI4 slave memory responder: one burst in flight, round-robin read/write grant,
// byte-strobed word array with per-transaction OKAY/SLVERR/DECERR responses.
module axi4_mem_slave_responder #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           ID_WIDTH   = 4,
   parameter int unsigned           MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   input  logic                      AWVALID,
   input  logic [ADDR_WIDTH-1:0]     AWADDR,
   input  logic [7:0]                AWLEN,
   input  logic [2:0]                AWSIZE,
   input  logic [1:0]                AWBURST,
   input  logic [ID_WIDTH-1:0]       AWID,
   output logic                      AWREADY,
   input  logic                      WVALID,
   input  logic [DATA_WIDTH-1:0]     WDATA,
   input  logic [DATA_WIDTH/8-1:0]   WSTRB,
   input  logic                      WLAST,
   output logic                      WREADY,
   output logic                      BVALID,
   output logic [1:0]                BRESP,
   output logic [ID_WIDTH-1:0]       BID,
   input  logic                      BREADY,
   input  logic                      ARVALID,
   input  logic [ADDR_WIDTH-1:0]     ARADDR,
   input  logic [7:0]                ARLEN,
   input  logic [2:0]                ARSIZE,
   input  logic [1:0]                ARBURST,
   input  logic [ID_WIDTH-1:0]       ARID,
   output logic                      ARREADY,
   output logic                      RVALID,
   output logic [DATA_WIDTH-1:0]     RDATA,
   output logic [1:0]                RRESP,
   output logic                      RLAST,
   output logic [ID_WIDTH-1:0]       RID,
   input  logic                      RREADY
);

   localparam int unsigned STRB_W     = DATA_WIDTH / 8;
   localparam int unsigned BYTE_SHIFT = $clog2(STRB_W);
   localparam int unsigned IDX_W      = $clog2(MEM_DEPTH);
   localparam logic [2:0]  MAX_SIZE   = 3'(BYTE_SHIFT);
   localparam logic [1:0]  RESP_OKAY   = 2'd0;
   localparam logic [1:0]  RESP_SLVERR = 2'd2;
   localparam logic [1:0]  RESP_DECERR = 2'd3;
   localparam logic [1:0]  BURST_FIXED = 2'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WDATA,
      S_WRESP,
      S_RDATA
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [7:0]            beat_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic                  slverr_q;
   logic                  decerr_q;
   logic                  rd_last_q;

   logic                  aw_hs, ar_hs, w_hs, r_hs;
   logic                  last_beat, in_range, wlast_err;
   logic [ADDR_WIDTH-1:0] step, addr_nxt, addr_off, word_addr;
   logic [IDX_W-1:0]      mem_idx;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   // WRAP and reserved bursts advance like INCR; they are only flagged as errors.
   always_comb begin
      step      = ADDR_WIDTH'(1) << size_q;
      addr_nxt  = (burst_q == BURST_FIXED) ? addr_q
                                           : ((addr_q & ~(step - ADDR_WIDTH'(1))) + step);
      addr_off  = addr_q - BASE_ADDR;
      word_addr = addr_off >> BYTE_SHIFT;
      in_range  = (addr_q >= BASE_ADDR) && (word_addr < ADDR_WIDTH'(MEM_DEPTH));
      mem_idx   = word_addr[IDX_W-1:0];
      last_beat = (beat_q == len_q);
      wlast_err = (WLAST != last_beat);
   end

   assign aw_hs = AWREADY;
   assign ar_hs = ARREADY;
   assign w_hs  = WREADY && WVALID;
   assign r_hs  = RVALID && RREADY;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      AWREADY   = 1'b0;
      ARREADY   = 1'b0;
      WREADY    = 1'b0;
      BVALID    = 1'b0;
      BRESP     = RESP_OKAY;
      BID       = '0;
      RVALID    = 1'b0;
      RDATA     = '0;
      RRESP     = RESP_OKAY;
      RLAST     = 1'b0;
      RID       = '0;
      case (state)
         S_IDLE: begin
            // Ready is gated by reset so every output is low while ARESETn is asserted.
            if (ARESETn) begin
               if (AWVALID && (!ARVALID || rd_last_q)) begin
                  AWREADY   = 1'b1;
                  state_nxt = S_WDATA;
               end else if (ARVALID) begin
                  ARREADY   = 1'b1;
                  state_nxt = S_RDATA;
               end
            end
         end
         S_WDATA: begin
            WREADY = 1'b1;
            if (WVALID && last_beat) state_nxt = S_WRESP;
         end
         S_WRESP: begin
            BVALID = 1'b1;
            BID    = id_q;
            if (decerr_q)      BRESP = RESP_DECERR;
            else if (slverr_q) BRESP = RESP_SLVERR;
            if (BREADY) state_nxt = S_IDLE;
         end
         S_RDATA: begin
            RVALID = 1'b1;
            RID    = id_q;
            RLAST  = last_beat;
            if (!in_range)     RRESP = RESP_DECERR;
            else if (slverr_q) RRESP = RESP_SLVERR;
            else               RDATA = mem[mem_idx];
            if (RREADY && last_beat) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         id_q      <= '0;
         slverr_q  <= 1'b0;
         decerr_q  <= 1'b0;
         rd_last_q <= 1'b1;
      end else if (aw_hs) begin
         addr_q    <= AWADDR;
         len_q     <= AWLEN;
         size_q    <= AWSIZE;
         burst_q   <= AWBURST;
         id_q      <= AWID;
         beat_q    <= '0;
         slverr_q  <= AWBURST[1] || (AWSIZE > MAX_SIZE);
         decerr_q  <= 1'b0;
         rd_last_q <= 1'b0;
      end else if (ar_hs) begin
         addr_q    <= ARADDR;
         len_q     <= ARLEN;
         size_q    <= ARSIZE;
         burst_q   <= ARBURST;
         id_q      <= ARID;
         beat_q    <= '0;
         slverr_q  <= ARBURST[1] || (ARSIZE > MAX_SIZE);
         decerr_q  <= 1'b0;
         rd_last_q <= 1'b1;
      end else if (w_hs) begin
         beat_q   <= beat_q + 8'd1;
         addr_q   <= addr_nxt;
         decerr_q <= decerr_q | ~in_range;
         slverr_q <= slverr_q | wlast_err;
      end else if (r_hs) begin
         beat_q <= beat_q + 8'd1;
         addr_q <= addr_nxt;
      end
   end

   // Array is deliberately not reset so contents survive ARESETn pulses.
   always_ff @(posedge ACLK) begin
      if (w_hs && in_range && !slverr_q && !wlast_err) begin
         for (int unsigned b = 0; b < STRB_W; b++) begin
            if (WSTRB[b]) mem[mem_idx][b*8 +: 8] <= WDATA[b*8 +: 8];
         end
      end
   end

endmodule
